// File: rtl/div_sequencer.sv
// Sequencer for the 32-bit iterative divider: sign handling, divide-by-zero/overflow
// short-cuts and a single-entry quotient/remainder cache for DIV/REM pairs.
module div_sequencer #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int DIV_LATENCY = 35
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o,
  output logic             div_load_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output logic             div_signed_o,
  input  logic [XLEN-1:0]  div_quotient_i,
  input  logic [XLEN-1:0]  div_remainder_i
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_LATENCY);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_FIX, S_RESP, S_DRAIN} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               op_rem_reg;
  logic [XLEN-1:0]    rs1_reg, rs2_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               signed_reg, neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]    q_raw_reg, r_raw_reg;
  logic               cache_valid_reg, cache_signed_reg;
  logic [XLEN-1:0]    cache_rs1_reg, cache_rs2_reg, cache_q_reg, cache_r_reg;
  logic               resp_valid_reg, div_load_reg;
  logic [XLEN-1:0]    resp_data_reg, dividend_reg, divisor_reg;
  logic [TAG_W-1:0]   resp_tag_reg;

  logic               accept, req_signed, is_zero, is_ovf, hit;
  logic [XLEN-1:0]    abs1, abs2, special_data, q_fix, r_fix;

  assign req_ready_o = (state_reg == S_IDLE) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign req_signed  = ~op_i[0];
  assign abs1 = (req_signed & rs1_i[XLEN-1]) ? (~rs1_i + XLEN'(1)) : rs1_i;
  assign abs2 = (req_signed & rs2_i[XLEN-1]) ? (~rs2_i + XLEN'(1)) : rs2_i;
  assign is_zero = (rs2_i == '0);
  assign is_ovf  = req_signed & (rs1_i == MIN_NEG) & (rs2_i == '1);
  // Divide-by-zero wins over overflow; both resolve without the divider.
  assign special_data = is_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : MIN_NEG);
  assign hit = cache_valid_reg & (rs1_i == cache_rs1_reg) & (rs2_i == cache_rs2_reg) &
               (req_signed == cache_signed_reg);
  assign q_fix = neg_q_reg ? (~q_raw_reg + XLEN'(1)) : q_raw_reg;
  assign r_fix = neg_r_reg ? (~r_raw_reg + XLEN'(1)) : r_raw_reg;

  assign resp_valid_o   = resp_valid_reg;
  assign resp_data_o    = resp_data_reg;
  assign resp_tag_o     = resp_tag_reg;
  assign busy_o         = (state_reg != S_IDLE);
  assign div_load_o     = div_load_reg;
  assign div_dividend_o = dividend_reg;
  assign div_divisor_o  = divisor_reg;
  assign div_signed_o   = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      op_rem_reg       <= 1'b0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      tag_reg          <= '0;
      signed_reg       <= 1'b0;
      neg_q_reg        <= 1'b0;
      neg_r_reg        <= 1'b0;
      q_raw_reg        <= '0;
      r_raw_reg        <= '0;
      cache_valid_reg  <= 1'b0;
      cache_signed_reg <= 1'b0;
      cache_rs1_reg    <= '0;
      cache_rs2_reg    <= '0;
      cache_q_reg      <= '0;
      cache_r_reg      <= '0;
      resp_valid_reg   <= 1'b0;
      resp_data_reg    <= '0;
      resp_tag_reg     <= '0;
      div_load_reg     <= 1'b0;
      dividend_reg     <= '0;
      divisor_reg      <= '0;
    end else begin
      div_load_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_rem_reg <= op_i[1];
            rs1_reg    <= rs1_i;
            rs2_reg    <= rs2_i;
            tag_reg    <= tag_i;
            signed_reg <= req_signed;
            neg_q_reg  <= req_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_r_reg  <= req_signed & rs1_i[XLEN-1];
            if (is_zero | is_ovf) begin
              resp_data_reg  <= special_data;
              resp_tag_reg   <= tag_i;
              resp_valid_reg <= 1'b1;
              state_reg      <= S_RESP;
            end else if (hit) begin
              resp_data_reg  <= op_i[1] ? cache_r_reg : cache_q_reg;
              resp_tag_reg   <= tag_i;
              resp_valid_reg <= 1'b1;
              state_reg      <= S_RESP;
            end else begin
              div_load_reg <= 1'b1;
              dividend_reg <= abs1;
              divisor_reg  <= abs2;
              state_reg    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cnt_reg <= CNT_W'(1);
          if (flush_i) begin
            cache_valid_reg <= 1'b0;
            state_reg       <= S_DRAIN;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            cache_valid_reg <= 1'b0;
            if (cnt_reg == CNT_MAX) begin
              cnt_reg   <= '0;
              state_reg <= S_IDLE;
            end else begin
              cnt_reg   <= cnt_reg + CNT_W'(1);
              state_reg <= S_DRAIN;
            end
          end else if (cnt_reg == CNT_MAX) begin
            q_raw_reg <= div_quotient_i;
            r_raw_reg <= div_remainder_i;
            cnt_reg   <= '0;
            state_reg <= S_FIX;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        // Divider may still be iterating; wait out the full count before reloading it.
        S_DRAIN: begin
          if (cnt_reg == CNT_MAX) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (flush_i) begin
            cache_valid_reg <= 1'b0;
            state_reg       <= S_IDLE;
          end else begin
            cache_valid_reg  <= 1'b1;
            cache_rs1_reg    <= rs1_reg;
            cache_rs2_reg    <= rs2_reg;
            cache_signed_reg <= signed_reg;
            cache_q_reg      <= q_fix;
            cache_r_reg      <= r_fix;
            resp_data_reg    <= op_rem_reg ? r_fix : q_fix;
            resp_tag_reg     <= tag_reg;
            resp_valid_reg   <= 1'b1;
            state_reg        <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush_i | resp_ready_i) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider on the back side, scoreboard of
// expected responses on the front side.
module tb_div_sequencer;
  localparam int L = 35;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  op_in = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  tag_in = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy, div_load, div_signed;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] m_q = 32'hDEADBEEF, m_r = 32'hBADC0FFE;

  div_sequencer #(.XLEN(32), .TAG_W(5), .DIV_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op_in), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag_in),
    .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_tag_o(resp_tag),
    .busy_o(busy),
    .div_load_o(div_load), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_signed_o(div_signed),
    .div_quotient_i(m_q), .div_remainder_i(m_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int loads = 0;
  int acc_cyc = 0;
  int m_cnt = 0;
  logic [31:0] last_dvd = '0, last_dvs = '0, m_a = '0, m_b = '0;
  logic [36:0] sb[$];

  // Divider model: outputs are junk until L-1 edges after the load edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_load) begin
      loads    <= loads + 1;
      last_dvd <= div_dividend;
      last_dvs <= div_divisor;
      m_a      <= div_dividend;
      m_b      <= div_divisor;
      m_cnt    <= L - 1;
      m_q      <= 32'hDEADBEEF;
      m_r      <= 32'hBADC0FFE;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_q <= (m_b != 0) ? m_a / m_b : 32'hFFFFFFFF;
        m_r <= (m_b != 0) ? m_a % m_b : m_a;
      end
    end
  end

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    sa = a;
    sbv = b;
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
    if (op[0]) return op[1] ? a % b : a / b;
    return op[1] ? sa % sbv : sa / sbv;
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; op_in = op; rs1 = a; rs2 = b; tag_in = tag;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL send_ready_timeout op=%0d got ready=%b want 1", op, req_ready); end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    sb.push_back({ref_result(op, a, b), tag});
  endtask

  // Waits for a response and completes the handshake; returns edges since accept.
  task automatic get_resp(output logic [31:0] d, output logic [4:0] t, output int lat);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!resp_valid) begin errors++; $display("FAIL resp_timeout got valid=%b want 1", resp_valid); end
    d = resp_data; t = resp_tag; lat = cyc - acc_cyc;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, busy, div_load, resp_data, resp_tag, div_dividend, div_divisor} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {resp_valid, busy, div_load, resp_data, resp_tag, div_dividend, div_divisor});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    $display("reset released ready=%b", req_ready);
  endtask

  task automatic test_divu;
    logic [31:0] d; logic [4:0] t; int lat, l0; logic [36:0] e;
    l0 = loads;
    send(2'b01, 32'd100, 32'd7, 5'd3);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("DIVU 100/7 data=%0d tag=%0d lat=%0d", d, t, lat);
    checks++; if (d !== e[36:5]) begin errors++; $display("FAIL divu_data got %h want %h", d, e[36:5]); end
    checks++; if (t !== e[4:0]) begin errors++; $display("FAIL divu_tag got %0d want %0d", t, e[4:0]); end
    checks++; if (lat !== L + 2) begin errors++; $display("FAIL divu_latency got %0d want %0d", lat, L + 2); end
    checks++; if (loads - l0 !== 1) begin errors++; $display("FAIL divu_loads got %0d want 1", loads - l0); end
    checks++; if ({last_dvd, last_dvs} !== {32'd100, 32'd7}) begin errors++; $display("FAIL divu_operands got %h/%h want 64/7", last_dvd, last_dvs); end
    checks++; if (div_signed !== 1'b0) begin errors++; $display("FAIL div_signed got %b want 0", div_signed); end
  endtask

  task automatic test_signed_cache;
    logic [31:0] d; logic [4:0] t; int lat, l0; logic [36:0] e;
    l0 = loads;
    send(2'b00, 32'hFFFFFFF9, 32'd2, 5'd4);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("DIV -7/2 data=%h tag=%0d lat=%0d", d, t, lat);
    checks++; if (d !== 32'hFFFFFFFD || d !== e[36:5]) begin errors++; $display("FAIL div_neg_data got %h want fffffffd", d); end
    checks++; if ({last_dvd, last_dvs} !== {32'd7, 32'd2}) begin errors++; $display("FAIL div_neg_magnitude got %h/%h want 7/2", last_dvd, last_dvs); end
    checks++; if (lat !== L + 2) begin errors++; $display("FAIL div_neg_latency got %0d want %0d", lat, L + 2); end
    l0 = loads;
    send(2'b10, 32'hFFFFFFF9, 32'd2, 5'd5);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("REM -7/2 (cached) data=%h tag=%0d lat=%0d", d, t, lat);
    checks++; if (d !== 32'hFFFFFFFF || t !== e[4:0]) begin errors++; $display("FAIL rem_hit_data got %h/%0d want ffffffff/%0d", d, t, e[4:0]); end
    // Fast-path responses are valid straight after the accept edge.
    checks++; if (lat !== 0 || loads != l0) begin errors++; $display("FAIL rem_hit_fast got lat=%0d loads=%0d want lat=0 loads=0", lat, loads - l0); end
    l0 = loads;
    send(2'b11, 32'hFFFFFFF9, 32'd2, 5'd6);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("REMU fffffff9/2 data=%h tag=%0d lat=%0d", d, t, lat);
    checks++; if (d !== 32'd1 || d !== e[36:5]) begin errors++; $display("FAIL remu_data got %h want 1", d); end
    checks++; if (loads - l0 !== 1 || last_dvd !== 32'hFFFFFFF9) begin errors++; $display("FAIL remu_no_hit got loads=%0d dvd=%h want 1/fffffff9", loads - l0, last_dvd); end
  endtask

  task automatic test_special;
    logic [1:0]  ops[4] = '{2'b00, 2'b11, 2'b00, 2'b10};
    logic [31:0] as[4]  = '{32'd5, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] want[4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d; logic [4:0] t; int lat, l0; logic [36:0] e;
      l0 = loads;
      send(ops[i], as[i], bs[i], 5'(10 + i));
      get_resp(d, t, lat);
      e = sb.pop_front();
      $display("special op=%0d %h/%h data=%h tag=%0d lat=%0d", ops[i], as[i], bs[i], d, t, lat);
      checks++; if (d !== want[i] || d !== e[36:5] || t !== e[4:0]) begin errors++; $display("FAIL special_data[%0d] got %h/%0d want %h/%0d", i, d, t, want[i], e[4:0]); end
      checks++; if (lat !== 0 || loads != l0) begin errors++; $display("FAIL special_fast[%0d] got lat=%0d loads=%0d want 0/0", i, lat, loads - l0); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] d; logic [4:0] t; int lat, l0, bad; logic [36:0] e;
    send(2'b00, 32'd1000, 32'hFFFFFFFD, 5'd1);
    get_resp(d, t, lat);
    e = sb.pop_front();
    checks++; if (d !== e[36:5]) begin errors++; $display("FAIL flush_pre_data got %h want %h", d, e[36:5]); end
    send(2'b00, 32'd77777, 32'd123, 5'd2);
    while (cyc < acc_cyc + 11) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_front());
    bad = 0;
    while (cyc < acc_cyc + L + 1) begin
      if (!busy || req_ready || resp_valid) bad++;
      @(negedge clk);
    end
    $display("flush drain ended at edge +%0d busy=%b ready=%b", cyc - acc_cyc, busy, req_ready);
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_drain_hold got %0d bad cycles want 0", bad); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_drain_end got busy=%b ready=%b want 0/1", busy, req_ready); end
    l0 = loads;
    send(2'b00, 32'd1000, 32'hFFFFFFFD, 5'd3);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("post-flush DIV 1000/-3 data=%h lat=%0d", d, lat);
    checks++; if (d !== e[36:5] || loads - l0 !== 1) begin errors++; $display("FAIL flush_invalidate got %h loads=%0d want %h loads=1", d, loads - l0, e[36:5]); end
    l0 = loads;
    send(2'b00, 32'd77777, 32'd123, 5'd4);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("post-flush DIV 77777/123 data=%h lat=%0d", d, lat);
    checks++; if (d !== e[36:5] || loads - l0 !== 1) begin errors++; $display("FAIL flush_rerun got %h loads=%0d want %h loads=1", d, loads - l0, e[36:5]); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d0; logic [4:0] t0; int n, bad; logic [36:0] e;
    send(2'b01, 32'd1000, 32'd10, 5'd9);
    e = sb.pop_front();
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    d0 = resp_data; t0 = resp_tag;
    checks++; if (!resp_valid || d0 !== e[36:5] || t0 !== e[4:0]) begin errors++; $display("FAIL bp_first got v=%b %h/%0d want 1 %h/%0d", resp_valid, d0, t0, e[36:5], e[4:0]); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== d0 || resp_tag !== t0) bad++;
    end
    $display("backpressure held data=%0d tag=%0d", d0, t0);
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b busy=%b ready=%b want 0/0/1", resp_valid, busy, req_ready); end
  endtask

  task automatic test_reset_midwait;
    logic [31:0] d; logic [4:0] t; int lat, l0; logic [36:0] e;
    send(2'b00, 32'h00012345, 32'h11, 5'd12);
    get_resp(d, t, lat);
    e = sb.pop_front();
    checks++; if (d !== e[36:5]) begin errors++; $display("FAIL rst_pre_data got %h want %h", d, e[36:5]); end
    send(2'b01, 32'h00ABCDEF, 32'h21, 5'd13);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("async reset mid-wait busy=%b dvd=%h", busy, div_dividend);
    checks++;
    if ({resp_valid, busy, div_load, resp_data, resp_tag, div_dividend, div_divisor} !== '0) begin
      errors++; $display("FAIL async_reset got %h want 0", {resp_valid, busy, div_load, resp_data, resp_tag, div_dividend, div_divisor});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    l0 = loads;
    send(2'b00, 32'h00012345, 32'h11, 5'd14);
    get_resp(d, t, lat);
    e = sb.pop_front();
    $display("post-reset DIV data=%h lat=%0d", d, lat);
    checks++; if (d !== e[36:5] || loads - l0 !== 1 || lat !== L + 2) begin errors++; $display("FAIL rst_cache_miss got %h loads=%0d lat=%0d want %h 1 %0d", d, loads - l0, lat, e[36:5], L + 2); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b, d; logic [4:0] t; int lat; logic [1:0] op; logic [36:0] e;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      send(op, a, b, 5'(i));
      get_resp(d, t, lat);
      e = sb.pop_front();
      $display("random op=%0d %h/%h data=%h tag=%0d", op, a, b, d, t);
      checks++; if (d !== e[36:5] || t !== e[4:0]) begin errors++; $display("FAIL random[%0d] got %h/%0d want %h/%0d", i, d, t, e[36:5], e[4:0]); end
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_signed_cache;
    test_special;
    test_flush;
    test_backpressure;
    test_reset_midwait;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Controller that sequences the 32-bit iterative divider (int_div_32) for RISC-V DIV/DIVU/REM/REMU.
- Sits between the execute-stage issue logic and the divider. Accepts requests on a valid/ready handshake and feeds the divider absolute-value operands in unsigned mode.
- Applies the result signs itself, resolves divide-by-zero and signed overflow without using the divider, and caches the last quotient/remainder pair so that DIV followed by REM on the same operands completes in one cycle.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the request tag (destination register).
- DIV_LATENCY, 35, posedge cycles from the load-pulse cycle until divider outputs are stable (covers the divider's 32 iterations plus its fix-up cycle plus margin).

Ports:
- clk_i  in  1  clock; controller logic is posedge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready at posedge.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; op_i[0]=1 means unsigned.
- rs1_i  in  XLEN  dividend.
- rs2_i  in  XLEN  divisor.
- tag_i  in  TAG_W  request tag.
- flush_i  in  1  abandon the in-flight operation.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when valid&ready at posedge.
- resp_data_o  out  XLEN  quotient or remainder.
- resp_tag_o  out  TAG_W  tag of the response.
- busy_o  out  1  high in any state other than IDLE.
- div_load_o  out  1  divider load strobe.
- div_dividend_o  out  XLEN  |rs1|, or rs1 for unsigned ops.
- div_divisor_o  out  XLEN  |rs2|, or rs2 for unsigned ops.
- div_signed_o  out  1  tied to 0; the divider always runs unsigned.
- div_quotient_i  in  XLEN  divider quotient.
- div_remainder_i  in  XLEN  divider remainder.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - State is IDLE; cache is invalid; the wait counter is 0.
  - resp_valid_o, div_load_o and busy_o are 0.
  - resp_data_o, resp_tag_o, div_dividend_o and div_divisor_o are 0.
- req_ready_o = (state==IDLE) & ~flush_i.
- On accept, latch op, rs1, rs2 and tag. Compute:
  - signed = ~op_i[0].
  - neg_q = signed & (rs1[XLEN-1] ^ rs2[XLEN-1]).
  - neg_r = signed & rs1[XLEN-1].
- Accept-path priority (highest first):
  1. Special case.
  2. Cache hit.
  3. Normal divide.
- Special cases go to RESP directly, with resp_valid_o high after the next edge. They do not update the cache.
  - rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF, DIV/REM): DIV gives 0x8000_0000; REM gives 0.
- Cache hit: cache valid, and rs1, rs2 and signed all equal the stored values. Go to RESP next edge, selecting the stored quotient or remainder by op_i[1].
- Normal path states:
  - LOAD (1 cycle): div_load_o=1; div_dividend_o and div_divisor_o are driven and then held stable until leaving WAIT.
  - WAIT: counter counts up to DIV_LATENCY. At that edge, capture div_quotient_i and div_remainder_i, then go to FIX.
  - FIX (1 cycle): quotient is negated (two's complement) if neg_q; remainder is negated if neg_r. Write rs1, rs2, signed, quotient and remainder into the cache and set cache valid. Go to RESP.
- Normal-path latency: accept at edge N gives resp_valid_o high after edge N+DIV_LATENCY+2.
- RESP:
  - resp_valid_o=1, with resp_data_o and resp_tag_o held stable until resp_ready_i.
  - On handshake, go to IDLE; resp_valid_o drops after that edge.
  - No new request is accepted in the handshake cycle.
- Flush:
  - In RESP: drop the response and go to IDLE next edge.
  - In LOAD/WAIT: invalidate the cache, suppress the response and go to DRAIN. DRAIN keeps counting until the WAIT count would have completed, then goes to IDLE. This prevents a load while the divider is still iterating.
  - Flush in IDLE or DRAIN has no effect.
  - Flush takes priority over a simultaneous req_valid_i, because req_ready_o is 0 while flush_i is high.
- Width rules:
  - Magnitude of x = x[XLEN-1] ? ~x+1 : x. The magnitude of 0x8000_0000 is 0x8000_0000, which is correct as unsigned.
  - All arithmetic wraps modulo 2^XLEN.
- A cache entry written by a signed op never hits for an unsigned op on the same operands, and vice versa.

Test Plan:
- DIVU rs1=100, rs2=7, tag=3 -> resp_data=14, tag=3, resp_valid high DIV_LATENCY+2 edges after accept; div_load_o pulses exactly once with div_signed_o=0.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 -> 0xFFFF_FFFD (-3). Then REM with the same operands -> 0xFFFF_FFFF (-1) one edge after accept, with no div_load_o pulse. Then REMU with the same operands -> divider runs (no cache hit) and returns 1.
- DIV x/0 gives 0xFFFF_FFFF; REMU 0x1234/0 gives 0x1234; DIV 0x8000_0000/0xFFFF_FFFF gives 0x8000_0000; REM of the same gives 0 -> every one responds after 1 edge with no div_load_o pulse.
- Flush 10 cycles into WAIT -> no response; busy_o stays high and req_ready_o stays low until the remaining WAIT count elapses. A following DIV with the same operands misses the cache and re-runs the divider.
- Response backpressure: hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o, resp_data_o and resp_tag_o stay stable. Release -> single handshake, then IDLE.
- Assert rst_ni low mid-WAIT -> all outputs are 0 immediately (asynchronous); after release, req_ready_o=1 and the first DIV misses the cache.
